cronometru_wb_slave: RTL and testbench
======================================

CRONOMETRU_WB_SLAVE -- requirements
Module: cronometru_wb_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, Wishbone data width; register fields occupy bits [7:0], upper bits read 0.
REQ-003 SHALL have parameter TICK_DIV, default 100000, clk cycles per centisecond tick; legal values are 2 or greater.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port wb_cyc_i, input, 1, bus cycle valid.
REQ-007 SHALL have port wb_stb_i, input, 1, strobe.
REQ-008 SHALL have port wb_we_i, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port wb_adr_i, input, ADDR_WIDTH, register address.
REQ-010 SHALL have port wb_dat_i, input, DATA_WIDTH, write data.
REQ-011 SHALL have port wb_dat_o, output, DATA_WIDTH, registered read data.
REQ-012 SHALL have port wb_ack_o, output, 1, registered transfer acknowledge.

Function
REQ-013 Register map: 0x000 CTRL, 0x001 STATUS, 0x002 CS (0-99), 0x003 SEC (0-59), 0x004 MIN (0-59), 0x005 LAP_CS, 0x006 LAP_SEC, 0x007 LAP_MIN (read-only); all other addresses are unmapped.
REQ-014 CTRL fields SHALL be: bit0 RUN (R/W); bit1 CLEAR (write-1, self-clearing, reads 0); bit2 LAP (write-1, self-clearing, reads 0).
REQ-015 STATUS fields SHALL be: bit0 RUNNING (mirror of RUN); bit1 OVF (sticky, write-1-to-clear).
REQ-016 wb_ack_o SHALL assert exactly one cycle after a clock edge sampling wb_cyc_i & wb_stb_i & !wb_ack_o, and SHALL be high for one cycle only.
REQ-017 Held strobe SHALL yield one ack every 2 cycles; one register side effect occurs per ack.
REQ-018 Writes SHALL take effect on the edge that raises wb_ack_o; wb_dat_o SHALL be valid in the same cycle wb_ack_o is high.
REQ-019 Unmapped addresses SHALL still be acked; reads return 0 and writes are ignored.
REQ-020 Prescaler: while RUN=1, count 0..TICK_DIV-1 and pulse an internal tick on reaching TICK_DIV-1, then wrap to 0; while RUN=0, hold the count.
REQ-021 On tick: CS increments; on 99->0, SEC increments; on 59->0, MIN increments; MIN 59->0 SHALL set OVF; all rollovers occur in the same cycle.
REQ-022 A read of CS SHALL snapshot SEC and MIN into shadows; reads of 0x003/0x004 return the shadows, giving a coherent CS-then-SEC-then-MIN read sequence.
REQ-023 Writes to CS/SEC/MIN while RUN=0 SHALL load the value, with out-of-range values (CS>99, SEC/MIN>59) loaded as 0; these writes are ignored while RUN=1.
REQ-024 CLEAR SHALL zero the prescaler, CS, SEC, MIN and OVF, but not the LAP registers; CLEAR beats a same-cycle tick.
REQ-025 LAP SHALL copy CS/SEC/MIN into LAP_*; a LAP coincident with a tick captures the pre-increment values.
REQ-026 A CTRL write with RUN=1 and CLEAR=1 SHALL clear, then start counting from 0 on the next cycle.
REQ-027 An OVF write-1-to-clear coincident with a MIN rollover SHALL leave OVF=1 (set wins).

Reset
REQ-028 rst_n low SHALL asynchronously force wb_ack_o=0, wb_dat_o=0, RUN=0, OVF=0, prescaler=0, and all time, lap and shadow registers to 0.
REQ-029 Reset asserted mid-transaction SHALL drop ack immediately; the interrupted access has no effect.
REQ-030 After rst_n deasserts, the first cycle/strobe SHALL be accepted on the next edge.

Verification (TICK_DIV=4)
REQ-031 Write CTRL=0x01, wait 400 clk, read CS -> 0x00, SEC -> 0x01, MIN -> 0x00; each ack is one cycle wide.
REQ-032 Stopped: write MIN=59, SEC=59, CS=99, then RUN=1 and wait 4 clk -> CS=0, SEC=0, MIN=0, STATUS=0x03; write STATUS=0x02 -> STATUS=0x01.
REQ-033 Running at CS=0x05: write CTRL=0x05 -> LAP_CS=0x05; write SEC=0x20 while running -> SEC unchanged.
REQ-034 Write CTRL=0x03 while running at SEC=7 -> CS/SEC/MIN=0, counting resumes, LAP unchanged; read 0x3FF -> ack, data 0x00.
REQ-035 Stopped: write CS=150 -> CS reads 0; hold stb for 6 cycles -> exactly 3 acks.
REQ-036 Pulse rst_n low during ack -> ack=0 at once, all registers read 0 after release.

Source files
------------

// File: rtl/cronometru_wb_slave.sv
// rtl/cronometru_wb_slave.sv - Wishbone stopwatch: centiseconds/seconds/minutes with lap capture.
module cronometru_wb_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int TICK_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_CS      = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_SEC     = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_MIN     = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_LAP_CS  = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_LAP_SEC = ADDR_WIDTH'(6);
    localparam logic [ADDR_WIDTH-1:0] A_LAP_MIN = ADDR_WIDTH'(7);

    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  run_q, run_d;
    logic                  ovf_q, ovf_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [6:0]            cs_q, cs_d;
    logic [5:0]            sec_q, sec_d;
    logic [5:0]            min_q, min_d;
    logic [6:0]            lap_cs_q, lap_cs_d;
    logic [5:0]            lap_sec_q, lap_sec_d;
    logic [5:0]            lap_min_q, lap_min_d;
    logic [5:0]            sec_sh_q, sec_sh_d;
    logic [5:0]            min_sh_q, min_sh_d;

    logic       access, wr, rd, tick;
    logic [7:0] wd;
    logic [7:0] rdata;
    logic [6:0] cs_load;
    logic [5:0] sm_load;

    always_comb begin
        access  = wb_cyc_i & wb_stb_i & ~ack_q;
        wr      = access & wb_we_i;
        rd      = access & ~wb_we_i;
        wd      = wb_dat_i[7:0];
        tick    = run_q && (presc_q == PRESC_MAX);
        cs_load = (wd > 8'd99) ? 7'd0 : wd[6:0];
        sm_load = (wd > 8'd59) ? 6'd0 : wd[5:0];

        ack_d     = access;
        dat_d     = dat_q;
        run_d     = run_q;
        ovf_d     = ovf_q;
        presc_d   = presc_q;
        cs_d      = cs_q;
        sec_d     = sec_q;
        min_d     = min_q;
        lap_cs_d  = lap_cs_q;
        lap_sec_d = lap_sec_q;
        lap_min_d = lap_min_q;
        sec_sh_d  = sec_sh_q;
        min_sh_d  = min_sh_q;

        rdata = 8'h00;
        case (wb_adr_i)
            A_CTRL:    rdata = {7'b0, run_q};
            A_STATUS:  rdata = {6'b0, ovf_q, run_q};
            A_CS:      rdata = {1'b0, cs_q};
            A_SEC:     rdata = {2'b0, sec_sh_q};
            A_MIN:     rdata = {2'b0, min_sh_q};
            A_LAP_CS:  rdata = {1'b0, lap_cs_q};
            A_LAP_SEC: rdata = {2'b0, lap_sec_q};
            A_LAP_MIN: rdata = {2'b0, lap_min_q};
            default:   rdata = 8'h00;
        endcase

        if (access) begin
            dat_d = '0;
            if (rd) begin
                dat_d[7:0] = rdata;
            end
        end

        // A CS read freezes SEC/MIN so a CS,SEC,MIN read sequence is coherent.
        if (rd && wb_adr_i == A_CS) begin
            sec_sh_d = sec_q;
            min_sh_d = min_q;
        end

        // OVF clear is applied before the tick so a coincident rollover wins.
        if (wr && wb_adr_i == A_STATUS && wd[1]) begin
            ovf_d = 1'b0;
        end

        if (run_q) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (tick) begin
            if (cs_q == 7'd99) begin
                cs_d = 7'd0;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d = 6'd0;
                        ovf_d = 1'b1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                cs_d = cs_q + 7'd1;
            end
        end

        if (wr && !run_q) begin
            if (wb_adr_i == A_CS)  cs_d  = cs_load;
            if (wb_adr_i == A_SEC) sec_d = sm_load;
            if (wb_adr_i == A_MIN) min_d = sm_load;
        end

        if (wr && wb_adr_i == A_CTRL) begin
            run_d = wd[0];
            // Lap samples the pre-tick, pre-clear time.
            if (wd[2]) begin
                lap_cs_d  = cs_q;
                lap_sec_d = sec_q;
                lap_min_d = min_q;
            end
            if (wd[1]) begin
                presc_d = '0;
                cs_d    = 7'd0;
                sec_d   = 6'd0;
                min_d   = 6'd0;
                ovf_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            run_q     <= 1'b0;
            ovf_q     <= 1'b0;
            presc_q   <= '0;
            cs_q      <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            lap_cs_q  <= '0;
            lap_sec_q <= '0;
            lap_min_q <= '0;
            sec_sh_q  <= '0;
            min_sh_q  <= '0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            run_q     <= run_d;
            ovf_q     <= ovf_d;
            presc_q   <= presc_d;
            cs_q      <= cs_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            lap_cs_q  <= lap_cs_d;
            lap_sec_q <= lap_sec_d;
            lap_min_q <= lap_min_d;
            sec_sh_q  <= sec_sh_d;
            min_sh_q  <= min_sh_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_cronometru_wb_slave.sv
// tb/tb_cronometru_wb_slave.sv - directed self-checking bench for cronometru_wb_slave.
module tb_cronometru_wb_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wb_cyc_i = 1'b0;
    logic       wb_stb_i = 1'b0;
    logic       wb_we_i = 1'b0;
    logic [9:0] wb_adr_i = '0;
    logic [7:0] wb_dat_i = '0;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    int checks = 0;
    int errors = 0;

    cronometru_wb_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .TICK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o)
    );

    always #5 clk = ~clk;

    task automatic bus(input logic we, input logic [9:0] adr, input logic [7:0] wd,
                       output logic [7:0] rdv, output int n);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = wd;
        n = 0;
        while (n < 8) begin
            @(posedge clk);
            #1;
            n++;
            if (wb_ack_o) break;
        end
        if (!wb_ack_o) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout adr=%h: ack=0, required ack=1 within 8 cycles", adr);
        end
        rdv = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [9:0] adr, input logic [7:0] wd);
        logic [7:0] d;
        int n;
        bus(1'b1, adr, wd, d, n);
    endtask

    task automatic rd(input logic [9:0] adr, output logic [7:0] d);
        int n;
        bus(1'b0, adr, 8'h00, d, n);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dat=%h, required ack=0 dat=00", wb_ack_o, wb_dat_o);
        end
        rst_n = 1'b1;
        bus(1'b0, 10'h000, 8'h00, d, n);
        checks++;
        if (n !== 1 || d !== 8'h00) begin
            errors++;
            $display("FAIL reset_first_access: cycles=%0d ctrl=%h, required cycles=1 ctrl=00", n, d);
        end
        rd(10'h001, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %h, required 00", d);
        end
    endtask

    task automatic test_run();
        logic [7:0] d;
        wr(10'h000, 8'h01);
        repeat (400) @(posedge clk);
        #1;
        rd(10'h002, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL run_cs: got %h, required 00", d);
        end
        rd(10'h003, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL run_sec: got %h, required 01", d);
        end
        rd(10'h004, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL run_min: got %h, required 00", d);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wb_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_width: ack=%b one cycle after ack, required 0", wb_ack_o);
        end
    endtask

    task automatic test_rollover();
        logic [7:0] d;
        wr(10'h000, 8'h00);
        wr(10'h000, 8'h02);
        wr(10'h004, 8'd59);
        wr(10'h003, 8'd59);
        wr(10'h002, 8'd99);
        wr(10'h000, 8'h01);
        repeat (4) @(posedge clk);
        #1;
        rd(10'h002, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL roll_cs: got %h, required 00", d);
        end
        rd(10'h003, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL roll_sec: got %h, required 00", d);
        end
        rd(10'h004, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL roll_min: got %h, required 00", d);
        end
        rd(10'h001, d);
        checks++;
        if (d !== 8'h03) begin
            errors++;
            $display("FAIL roll_status: got %h, required 03", d);
        end
        wr(10'h001, 8'h02);
        rd(10'h001, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL ovf_w1c: got %h, required 01", d);
        end
    endtask

    task automatic test_ovf_set_wins();
        logic [7:0] d;
        wr(10'h000, 8'h00);
        wr(10'h000, 8'h02);
        wr(10'h004, 8'd59);
        wr(10'h003, 8'd59);
        wr(10'h002, 8'd99);
        wr(10'h000, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        wr(10'h001, 8'h02);
        rd(10'h001, d);
        checks++;
        if (d !== 8'h03) begin
            errors++;
            $display("FAIL ovf_set_wins: got %h, required 03", d);
        end
    endtask

    task automatic test_lap();
        logic [7:0] d;
        wr(10'h000, 8'h00);
        wr(10'h000, 8'h02);
        wr(10'h002, 8'h05);
        wr(10'h000, 8'h05);
        rd(10'h005, d);
        checks++;
        if (d !== 8'h05) begin
            errors++;
            $display("FAIL lap_cs: got %h, required 05", d);
        end
        rd(10'h006, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL lap_sec: got %h, required 00", d);
        end
        wr(10'h003, 8'h20);
        rd(10'h002, d);
        checks++;
        if (d !== 8'h06) begin
            errors++;
            $display("FAIL lap_running_cs: got %h, required 06", d);
        end
        rd(10'h003, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL sec_write_ignored: got %h, required 00", d);
        end
    endtask

    task automatic test_clear_run();
        logic [7:0] d;
        wr(10'h000, 8'h00);
        wr(10'h003, 8'd7);
        rd(10'h002, d);
        rd(10'h003, d);
        checks++;
        if (d !== 8'h07) begin
            errors++;
            $display("FAIL sec_load: got %h, required 07", d);
        end
        wr(10'h000, 8'h01);
        wr(10'h000, 8'h03);
        repeat (10) @(posedge clk);
        #1;
        rd(10'h002, d);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("FAIL clear_run_cs: got %h, required 02", d);
        end
        rd(10'h003, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL clear_run_sec: got %h, required 00", d);
        end
        rd(10'h005, d);
        checks++;
        if (d !== 8'h05) begin
            errors++;
            $display("FAIL clear_keeps_lap: got %h, required 05", d);
        end
        wr(10'h3FF, 8'hFF);
        rd(10'h3FF, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_read: got %h, required 00", d);
        end
    endtask

    task automatic test_range_and_hold();
        logic [7:0] d;
        int acks;
        wr(10'h000, 8'h00);
        wr(10'h002, 8'd150);
        rd(10'h002, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL cs_out_of_range: got %h, required 00", d);
        end
        wr(10'h002, 8'd99);
        wr(10'h003, 8'd60);
        wr(10'h004, 8'd59);
        rd(10'h002, d);
        checks++;
        if (d !== 8'd99) begin
            errors++;
            $display("FAIL cs_max_load: got %h, required 63", d);
        end
        rd(10'h003, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL sec_out_of_range: got %h, required 00", d);
        end
        rd(10'h004, d);
        checks++;
        if (d !== 8'd59) begin
            errors++;
            $display("FAIL min_max_load: got %h, required 3b", d);
        end
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 10'h002;
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (wb_ack_o) acks++;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        checks++;
        if (acks !== 3) begin
            errors++;
            $display("FAIL held_strobe_acks: got %0d, required 3", acks);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int n;
        wr(10'h000, 8'h05);
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 10'h000;
        @(posedge clk);
        #1;
        checks++;
        if (wb_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack_high: ack=%b, required 1", wb_ack_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_async: ack=%b dat=%h, required ack=0 dat=00", wb_ack_o, wb_dat_o);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus(1'b0, 10'h002, 8'h00, d, n);
        checks++;
        if (n !== 1 || d !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_cs: cycles=%0d data=%h, required cycles=1 data=00", n, d);
        end
        for (int a = 0; a < 8; a++) begin
            rd(10'(a), d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL post_reset_reg%0d: got %h, required 00", a, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_rollover();
        test_ovf_set_wins();
        test_lap();
        test_clear_run();
        test_range_and_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
